// File: rtl/ctr_xor_output_stage_if.sv
// AXI-Stream style bundle for the CTR output stage; the keystream side uses the tlast-free modport.
interface ctr_xor_output_stage_if #(
  parameter int DATA_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

  modport slave_data (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/ctr_xor_output_stage.sv
// AES-CTR final stage: joins plaintext and keystream, XORs them into a 2-entry output buffer.
// Output one cycle after the joint handshake; both inputs stall together only when the buffer is full.
module ctr_xor_output_stage #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  ctr_xor_output_stage_if.slave      s_pt,
  ctr_xor_output_stage_if.slave_data s_ks,
  ctr_xor_output_stage_if.master     m_axis,
  output logic [CNT_WIDTH-1:0]       word_count,
  output logic [CNT_WIDTH-1:0]       pkt_count,
  output logic                       pkt_done
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  occ_q;
  logic                  can_accept_q;
  logic [DATA_WIDTH-1:0] head_dat_q;
  logic                  head_last_q;
  logic [DATA_WIDTH-1:0] tail_dat_q;
  logic                  tail_last_q;

  logic [CNT_WIDTH-1:0]  word_count_q;
  logic [CNT_WIDTH-1:0]  word_count_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q;
  logic [CNT_WIDTH-1:0]  pkt_count_d;
  logic                  pkt_done_q;
  logic                  pkt_done_d;

  logic                  fire;
  logic                  pop;
  logic [DATA_WIDTH-1:0] ct_dat;

  // Each ready depends only on the other stream's valid, so no valid ever waits on a ready.
  assign s_pt.tready = s_ks.tvalid && can_accept_q;
  assign s_ks.tready = s_pt.tvalid && can_accept_q;

  assign fire   = s_pt.tvalid && s_ks.tvalid && can_accept_q;
  assign ct_dat = s_pt.tdata ^ s_ks.tdata;

  assign m_axis.tvalid = (occ_q != OCC_EMPTY);
  assign m_axis.tdata  = head_dat_q;
  assign m_axis.tlast  = head_last_q;
  assign pop           = m_axis.tvalid && m_axis.tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q        <= OCC_EMPTY;
      can_accept_q <= 1'b0;
      head_dat_q   <= '0;
      head_last_q  <= 1'b0;
      tail_dat_q   <= '0;
      tail_last_q  <= 1'b0;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          can_accept_q <= 1'b1;
          if (fire) begin
            head_dat_q  <= ct_dat;
            head_last_q <= s_pt.tlast;
            occ_q       <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          can_accept_q <= !(fire && !pop);
          if (fire && !pop) begin
            tail_dat_q  <= ct_dat;
            tail_last_q <= s_pt.tlast;
            occ_q       <= OCC_TWO;
          end else if (fire && pop) begin
            head_dat_q  <= ct_dat;
            head_last_q <= s_pt.tlast;
          end else if (pop) begin
            occ_q <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            head_dat_q   <= tail_dat_q;
            head_last_q  <= tail_last_q;
            occ_q        <= OCC_ONE;
            can_accept_q <= 1'b1;
          end
        end
        default: begin
          occ_q        <= OCC_EMPTY;
          can_accept_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    word_count_d = word_count_q;
    pkt_count_d  = pkt_count_q;
    pkt_done_d   = 1'b0;
    if (pop) begin
      if (head_last_q) begin
        word_count_d = '0;
        pkt_count_d  = pkt_count_q + CNT_WIDTH'(1);
        pkt_done_d   = 1'b1;
      end else begin
        word_count_d = word_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count_q <= '0;
      pkt_count_q  <= '0;
      pkt_done_q   <= 1'b0;
    end else begin
      word_count_q <= word_count_d;
      pkt_count_q  <= pkt_count_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign word_count = word_count_q;
  assign pkt_count  = pkt_count_q;
  assign pkt_done   = pkt_done_q;

endmodule
